// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one req/ack data-memory access per load/store,
// stalls the pipeline while it is outstanding and reports misalignment and bus timeouts.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] alu_c,
    input  logic [31:0] st_data,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        addr_err,
    output logic        bus_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    // Last no-ack WAIT cycle index before the access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_SB);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lane);
        logic mis;
        case (op)
            OP_LW, OP_SW:         mis = (lane != 2'b00);
            OP_LH, OP_LHU, OP_SH: mis = lane[0];
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] extract_load(input logic [3:0] op, input logic [1:0] lane,
                                                 input logic [31:0] rd);
        logic [15:0] half;
        logic [7:0]  byt;
        logic [31:0] res;
        half = lane[1] ? rd[31:16] : rd[15:0];
        case (lane)
            2'd0:    byt = rd[7:0];
            2'd1:    byt = rd[15:8];
            2'd2:    byt = rd[23:16];
            default: byt = rd[31:24];
        endcase
        case (op)
            OP_LW:   res = rd;
            OP_LH:   res = {{16{half[15]}}, half};
            OP_LHU:  res = {16'h0000, half};
            OP_LB:   res = {{24{byt[7]}}, byt};
            OP_LBU:  res = {24'h000000, byt};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    logic [1:0]  state_r;
    logic [3:0]  op_r;
    logic [1:0]  lane_r;
    logic [7:0]  cnt_r;
    logic        dm_req_r;
    logic        dm_we_r;
    logic [31:0] dm_addr_r;
    logic [3:0]  dm_be_r;
    logic [31:0] dm_wdata_r;
    logic [31:0] load_data_r;
    logic        load_valid_r;
    logic        addr_err_r;
    logic        bus_err_r;

    logic        start_s;
    logic        mis_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    assign start_s = ex_valid && is_mem_op(mem_op) && (state_r == ST_IDLE);
    assign mis_s   = is_misaligned(mem_op, alu_c[1:0]);

    // Byte enables and lane-replicated write data for the access being started.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = 32'h0000_0000;
        case (mem_op)
            OP_SW: begin
                be_s    = 4'b1111;
                wdata_s = st_data;
            end
            OP_SH: begin
                be_s    = alu_c[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{st_data[15:0]}};
            end
            OP_SB: begin
                be_s    = 4'b0001 << alu_c[1:0];
                wdata_s = {4{st_data[7:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Access FSM, request registers, timeout counter and result/error pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            op_r         <= 4'd0;
            lane_r       <= 2'd0;
            cnt_r        <= 8'd0;
            dm_req_r     <= 1'b0;
            dm_we_r      <= 1'b0;
            dm_addr_r    <= 32'h0000_0000;
            dm_be_r      <= 4'b0000;
            dm_wdata_r   <= 32'h0000_0000;
            load_data_r  <= 32'h0000_0000;
            load_valid_r <= 1'b0;
            addr_err_r   <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            load_valid_r <= 1'b0;
            addr_err_r   <= 1'b0;
            bus_err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        if (mis_s) begin
                            addr_err_r <= 1'b1;
                        end else begin
                            state_r    <= ST_WAIT;
                            dm_req_r   <= 1'b1;
                            dm_we_r    <= is_store(mem_op);
                            dm_addr_r  <= {alu_c[31:2], 2'b00};
                            dm_be_r    <= be_s;
                            dm_wdata_r <= wdata_s;
                            lane_r     <= alu_c[1:0];
                            op_r       <= mem_op;
                            cnt_r      <= 8'd0;
                        end
                    end
                end
                ST_WAIT: begin
                    // An ack arriving on the timeout cycle still completes normally.
                    if (dm_ack) begin
                        state_r  <= ST_DONE;
                        dm_req_r <= 1'b0;
                        if (!is_store(op_r)) begin
                            load_data_r  <= extract_load(op_r, lane_r, dm_rdata);
                            load_valid_r <= 1'b1;
                        end
                    end else if (cnt_r == TO_LAST) begin
                        state_r     <= ST_DONE;
                        dm_req_r    <= 1'b0;
                        bus_err_r   <= 1'b1;
                        load_data_r <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    dm_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall      = (start_s && !mis_s) || (state_r == ST_WAIT);
    assign dm_req     = dm_req_r;
    assign dm_we      = dm_we_r;
    assign dm_addr    = dm_addr_r;
    assign dm_be      = dm_be_r;
    assign dm_wdata   = dm_wdata_r;
    assign load_data  = load_data_r;
    assign load_valid = load_valid_r;
    assign addr_err   = addr_err_r;
    assign bus_err    = bus_err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit (timeout shortened to 4 cycles).
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ex_valid;
    logic [3:0]  mem_op;
    logic [31:0] alu_c;
    logic [31:0] st_data;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        addr_err;
    logic        bus_err;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .mem_op(mem_op), .alu_c(alu_c),
        .st_data(st_data), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
        .load_data(load_data), .load_valid(load_valid), .addr_err(addr_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          dly;       // WAIT cycle (1-based) carrying dm_ack; 0 = never
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        logic        e_aerr;
        logic        e_berr;
        logic        e_lv;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int stalls;
        ex_valid = 1'b1;
        mem_op   = v.op;
        alu_c    = v.addr;
        st_data  = v.sdata;
        #1;
        chk({tag, ".stall_start"}, 32'(stall), 32'(!v.e_aerr));
        @(posedge clk); #1;
        if (v.e_aerr) begin
            ex_valid = 1'b0;
            mem_op   = 4'd0;
            #1;
            chk({tag, ".addr_err"}, 32'(addr_err), 32'd1);
            chk({tag, ".no_req"}, 32'(dm_req), 32'd0);
            chk({tag, ".no_stall"}, 32'(stall), 32'd0);
            @(posedge clk); #1;
            chk({tag, ".addr_err_pulse"}, 32'(addr_err), 32'd0);
            chk({tag, ".no_req2"}, 32'(dm_req), 32'd0);
        end else begin
            n      = 0;
            stalls = 1;
            while (stall && n < 20) begin
                if (n == 0) begin
                    chk({tag, ".req"}, 32'(dm_req), 32'd1);
                    chk({tag, ".we"}, 32'(dm_we), 32'(v.e_we));
                    chk({tag, ".addr"}, dm_addr, v.e_addr);
                    chk({tag, ".be"}, 32'(dm_be), 32'(v.e_be));
                    chk({tag, ".wdata"}, dm_wdata, v.e_wdata);
                end
                n++;
                stalls++;
                if (n == v.dly) begin
                    dm_ack   = 1'b1;
                    dm_rdata = v.rdata;
                end
                @(posedge clk); #1;
                dm_ack   = 1'b0;
                dm_rdata = 32'h5A5A_A5A5;
            end
            chk({tag, ".stall_cycles"}, 32'(stalls), 32'(v.e_berr ? 1 + TO : 1 + v.dly));
            chk({tag, ".done_req"}, 32'(dm_req), 32'd0);
            chk({tag, ".load_valid"}, 32'(load_valid), 32'(v.e_lv));
            chk({tag, ".bus_err"}, 32'(bus_err), 32'(v.e_berr));
            chk({tag, ".load_data"}, load_data, v.e_ld);
            ex_valid = 1'b0;
            mem_op   = 4'd0;
            @(posedge clk); #1;
            chk({tag, ".lv_pulse"}, 32'(load_valid), 32'd0);
            chk({tag, ".berr_pulse"}, 32'(bus_err), 32'd0);
        end
    endtask

    initial begin
        //          op    addr          sdata         rdata         dly e_addr        be       wdata         we    aerr  berr  lv    ld
        vecs[0]  = '{4'd1, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 32'h0000_0100, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{4'd4, 32'h0000_0103, 32'h0,        32'h80FF_0011, 1, 32'h0000_0100, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FF80};
        vecs[2]  = '{4'd5, 32'h0000_0103, 32'h0,        32'h80FF_0011, 2, 32'h0000_0100, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080};
        vecs[3]  = '{4'd2, 32'h0000_0102, 32'h0,        32'h80FF_0011, 1, 32'h0000_0100, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_80FF};
        vecs[4]  = '{4'd3, 32'h0000_0102, 32'h0,        32'h80FF_0011, 1, 32'h0000_0100, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_80FF};
        vecs[5]  = '{4'd7, 32'h0000_0206, 32'h1234_5678, 32'h0,        1, 32'h0000_0204, 4'b1100, 32'h5678_5678, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_80FF};
        vecs[6]  = '{4'd8, 32'h0000_0201, 32'h0000_00AB, 32'h0,        1, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_80FF};
        vecs[7]  = '{4'd1, 32'h0000_0102, 32'h0,        32'h0,        1, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{4'd7, 32'h0000_0101, 32'h0,        32'h0,        1, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{4'd1, 32'h0000_0300, 32'h0,        32'h1122_3344, 3, 32'h0000_0300, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h1122_3344};
        vecs[10] = '{4'd6, 32'h0000_0304, 32'hCAFE_F00D, 32'h0,        3, 32'h0000_0304, 4'b1111, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1122_3344};
        vecs[11] = '{4'd4, 32'h0000_0002, 32'h0,        32'h007F_0000, 1, 32'h0000_0000, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_007F};
        vecs[12] = '{4'd1, 32'h0000_0400, 32'h0,        32'h0,        0, 32'h0000_0400, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0};

        rstn     = 1'b0;
        ex_valid = 1'b0;
        mem_op   = 4'd0;
        alu_c    = 32'h0;
        st_data  = 32'h0;
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.dm_req", 32'(dm_req), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.dm_addr", dm_addr, 32'h0);
        chk("rst.dm_be", 32'(dm_be), 32'h0);
        chk("rst.load_data", load_data, 32'h0);
        chk("rst.flags", {29'd0, load_valid, addr_err, bus_err}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Mem op code outside 1..8 with ex_valid set: no activity.
        ex_valid = 1'b1;
        mem_op   = 4'd12;
        alu_c    = 32'h0000_0102;
        #1;
        chk("noneop.stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("noneop.req", 32'(dm_req), 32'd0);
        chk("noneop.addr_err", 32'(addr_err), 32'd0);
        ex_valid = 1'b0;
        mem_op   = 4'd0;

        // Stray ack while idle is ignored.
        dm_ack   = 1'b1;
        dm_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("stray_ack.lv", 32'(load_valid), 32'd0);
        chk("stray_ack.ld", load_data, 32'h0);

        // Asynchronous reset while an access is outstanding.
        ex_valid = 1'b1;
        mem_op   = 4'd1;
        alu_c    = 32'h0000_0500;
        @(posedge clk); #1;
        chk("midrst.req_before", 32'(dm_req), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst.req_dropped", 32'(dm_req), 32'd0);
        ex_valid = 1'b0;
        mem_op   = 4'd0;
        #1;
        chk("midrst.stall", 32'(stall), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("midrst.idle_req", 32'(dm_req), 32'd0);
        chk("midrst.no_err", {30'd0, addr_err, bus_err}, 32'h0);

        run_vec(vecs[0], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
